// File: rtl/axis_input_queue.sv
// axis_input_queue: per-channel AXI-Stream flit buffer feeding one lane of the
// router's round-robin packet arbiter. It decouples link backpressure from
// arbitration and tracks packet boundaries from the routing-header beat.
//
// Optional feature macro: AXIS_INPUT_QUEUE_STORE_AND_FORWARD_EN
//   defined   -> the head packet is presented only once it is fully stored,
//                with a cut-through fallback when the queue is full
//   undefined -> pure cut-through, a stored beat is presented immediately

package axis_input_queue_pkg;

   localparam int AXIS_DATA_WIDTH = 32;
   localparam int AXIS_TID_WIDTH  = 2;

   // TID value that marks the routing-header beat of a packet
   localparam logic [AXIS_TID_WIDTH-1:0] ROUTING_HEADER = 2'b01;

   typedef struct packed {
      logic [AXIS_DATA_WIDTH-1:0] TDATA;
      logic [AXIS_TID_WIDTH-1:0]  TID;
   } axis_data_t;

   typedef struct packed {
      axis_data_t data;
      logic       TVALID;
   } axis_mosi_t;

   typedef struct packed {
      logic TREADY;
   } axis_miso_t;

endpackage

module axis_input_queue
   import axis_input_queue_pkg::*;
#(
   parameter int DEPTH               = 8,
   parameter int DEPTH_WIDTH         = $clog2(DEPTH),
   parameter int MAX_ROUTERS_X       = 4,
   parameter int MAX_ROUTERS_X_WIDTH = $clog2(MAX_ROUTERS_X),
   parameter int MAX_ROUTERS_Y       = 4,
   parameter int MAX_ROUTERS_Y_WIDTH = $clog2(MAX_ROUTERS_Y)
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  axis_mosi_t           in_mosi_i,
   output axis_miso_t           in_miso_o,
   output axis_mosi_t           out_mosi_o,
   input  axis_miso_t           out_miso_i,
   output logic [DEPTH_WIDTH:0] count_o,
   output logic [DEPTH_WIDTH:0] pkts_ready_o
);

   // The body length sits just above the destination and source X/Y fields
   localparam int LEN_LSB = (MAX_ROUTERS_X_WIDTH + MAX_ROUTERS_Y_WIDTH) * 2;

   localparam logic [DEPTH_WIDTH:0]   CNT_ONE   = 1;
   localparam logic [DEPTH_WIDTH:0]   CNT_FULL  = DEPTH[DEPTH_WIDTH:0];
   localparam logic [DEPTH_WIDTH-1:0] PTR_ONE   = 1;

   typedef enum logic {
      RX_IDLE,
      RX_BODY
   } rx_state_t;

   typedef enum logic {
      TX_IDLE,
      TX_BODY
   } tx_state_t;

   axis_data_t             mem [DEPTH];
   logic [DEPTH_WIDTH-1:0] wr_ptr;
   logic [DEPTH_WIDTH-1:0] rd_ptr;

   logic                   full;
   logic                   empty;
   logic                   push;
   logic                   pop;
   logic                   out_valid;
   axis_data_t             head;

   logic                   in_is_header;
   logic [7:0]             in_len;
   logic                   head_is_header;
   logic [7:0]             head_len;

   rx_state_t              rx_state;
   rx_state_t              rx_state_next;
   logic [7:0]             rx_left;
   logic [7:0]             rx_left_next;
   logic                   rx_complete;

   tx_state_t              tx_state;
   tx_state_t              tx_state_next;
   logic [7:0]             tx_left;
   logic [7:0]             tx_left_next;
   logic                   tx_depart;

   assign full  = (count_o == CNT_FULL);
   assign empty = (count_o == '0);
   assign head  = mem[rd_ptr];

   assign push  = in_mosi_i.TVALID && !full;
   assign pop   = out_valid && out_miso_i.TREADY;

   assign in_is_header   = (in_mosi_i.data.TID == ROUTING_HEADER);
   assign in_len         = in_mosi_i.data.TDATA[LEN_LSB +: 8];
   assign head_is_header = (head.TID == ROUTING_HEADER);
   assign head_len       = head.TDATA[LEN_LSB +: 8];

   // Presentation rule for the head beat; store-and-forward waits for a whole packet
`ifdef AXIS_INPUT_QUEUE_STORE_AND_FORWARD_EN
   logic tx_in_packet;
   assign tx_in_packet = (tx_state == TX_BODY);
   always_comb begin
      out_valid = !empty && ((pkts_ready_o != '0) || tx_in_packet || full);
   end
`else
   always_comb begin
      out_valid = !empty;
   end
`endif

   // Drive both stream interfaces from the storage head and the occupancy
   always_comb begin
      out_mosi_o.data   = head;
      out_mosi_o.TVALID = out_valid;
      in_miso_o.TREADY  = !full;
   end

   // Flit storage; contents need no reset since occupancy gates every read
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr] <= in_mosi_i.data;
      end
   end

   // Write and read pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   // Occupancy: a simultaneous push and pop leaves the count unchanged
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         count_o <= '0;
      end else begin
         case ({push, pop})
            2'b10:   count_o <= count_o + CNT_ONE;
            2'b01:   count_o <= count_o - CNT_ONE;
            default: count_o <= count_o;
         endcase
      end
   end

   // RX packet tracker state register
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rx_state <= RX_IDLE;
         rx_left  <= '0;
      end else begin
         rx_state <= rx_state_next;
         rx_left  <= rx_left_next;
      end
   end

   // RX decode: a header opens a packet, stray beats and empty headers close at once
   always_comb begin
      rx_state_next = rx_state;
      rx_left_next  = rx_left;
      rx_complete   = 1'b0;
      if (push) begin
         case (rx_state)
            RX_IDLE: begin
               if (in_is_header && (in_len != 8'd0)) begin
                  rx_state_next = RX_BODY;
                  rx_left_next  = in_len;
               end else begin
                  rx_complete = 1'b1;
               end
            end
            RX_BODY: begin
               rx_left_next = rx_left - 8'd1;
               if (rx_left == 8'd1) begin
                  rx_complete   = 1'b1;
                  rx_state_next = RX_IDLE;
               end
            end
            default: begin
               rx_state_next = RX_IDLE;
            end
         endcase
      end
   end

   // TX packet tracker state register
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         tx_state <= TX_IDLE;
         tx_left  <= '0;
      end else begin
         tx_state <= tx_state_next;
         tx_left  <= tx_left_next;
      end
   end

   // TX decode mirrors RX on popped beats to see when a packet has left
   always_comb begin
      tx_state_next = tx_state;
      tx_left_next  = tx_left;
      tx_depart     = 1'b0;
      if (pop) begin
         case (tx_state)
            TX_IDLE: begin
               if (head_is_header && (head_len != 8'd0)) begin
                  tx_state_next = TX_BODY;
                  tx_left_next  = head_len;
               end else begin
                  tx_depart = 1'b1;
               end
            end
            TX_BODY: begin
               tx_left_next = tx_left - 8'd1;
               if (tx_left == 8'd1) begin
                  tx_depart     = 1'b1;
                  tx_state_next = TX_IDLE;
               end
            end
            default: begin
               tx_state_next = TX_IDLE;
            end
         endcase
      end
   end

   // Complete packets held: arrivals minus departures, same rule as occupancy
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pkts_ready_o <= '0;
      end else begin
         case ({rx_complete, tx_depart})
            2'b10:   pkts_ready_o <= pkts_ready_o + CNT_ONE;
            2'b01:   pkts_ready_o <= pkts_ready_o - CNT_ONE;
            default: pkts_ready_o <= pkts_ready_o;
         endcase
      end
   end

endmodule

// File: tb/tb_axis_input_queue.sv
// tb_axis_input_queue: scoreboard bench for axis_input_queue. The driver
// records each accepted beat, tagged with its packet position, into an
// expected queue; an independent monitor checks occupancy, packet count,
// handshakes and popped data against that queue every cycle.

module tb_axis_input_queue;
   import axis_input_queue_pkg::*;

   localparam int DEPTH   = 8;
   localparam int DW      = 3;
   localparam int LEN_LSB = 8;

   typedef struct {
      axis_data_t data;
      bit         first;
      bit         last;
   } exp_beat_t;

   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   axis_mosi_t  inMosi;
   axis_miso_t  inMiso;
   axis_mosi_t  outMosi;
   axis_miso_t  outMiso;
   logic [DW:0] count;
   logic [DW:0] pkts;

   exp_beat_t   expQ[$];
   int          completedIn = 0;
   int          departed = 0;
   bit          inPkt = 0;
   bit          randReady = 0;
   int          readyPct = 60;
   int          checkCount = 0;
   int          passCount = 0;

   axis_input_queue #(
      .DEPTH(DEPTH)
   ) dut (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .in_mosi_i   (inMosi),
      .in_miso_o   (inMiso),
      .out_mosi_o  (outMosi),
      .out_miso_i  (outMiso),
      .count_o     (count),
      .pkts_ready_o(pkts)
   );

   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive one beat and record it in the scoreboard once it is accepted
   task automatic applyStimulus(input axis_data_t beat, input bit first, input bit last);
      int waitCycles;
      bit ok;
      exp_beat_t e;
      inMosi.data   = beat;
      inMosi.TVALID = 1'b1;
      waitCycles = 0;
      ok = 1'b0;
      while (!ok && waitCycles < 300) begin
         @(negedge clk_i);
         if (inMiso.TREADY) ok = 1'b1;
         else waitCycles++;
      end
      if (!ok) checkOutput("push_timeout", inMiso.TREADY, 1);
      @(posedge clk_i);
      if (ok) begin
         e.data  = beat;
         e.first = first;
         e.last  = last;
         expQ.push_back(e);
         if (last) completedIn++;
      end
      #1 inMosi.TVALID = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   function automatic axis_data_t makeHeader(input int n);
      axis_data_t h;
      h.TDATA = $urandom;
      h.TDATA[LEN_LSB +: 8] = n[7:0];
      h.TID = ROUTING_HEADER;
      return h;
   endfunction

   task automatic sendPacket(input int n, input int gapPct);
      axis_data_t b;
      applyStimulus(makeHeader(n), 1'b1, n == 0);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 99) < gapPct) idleCycles($urandom_range(1, 3));
         b.TDATA = $urandom;
         b.TID   = 2'($urandom_range(0, 3));
         applyStimulus(b, 1'b0, i == n - 1);
      end
   endtask

   task automatic sendStray();
      axis_data_t b;
      b.TDATA = $urandom;
      b.TID   = 2'($urandom_range(0, 3));
      while (b.TID == ROUTING_HEADER) b.TID = 2'($urandom_range(0, 3));
      applyStimulus(b, 1'b1, 1'b1);
   endtask

   task automatic waitDrain(input int budget);
      int c;
      c = 0;
      while (expQ.size() != 0 && c < budget) begin
         @(posedge clk_i);
         c++;
      end
      #1;
      checkOutput("drain_count", count, 0);
   endtask

   // Monitor: compare DUT state with the scoreboard and consume popped beats
   always @(negedge clk_i) begin : monitor
      int pend;
      bit expValid;
      exp_beat_t e;
      if (rst_n_i) begin
         pend = completedIn - departed;
         checkOutput("count", count, expQ.size());
         checkOutput("pkts_ready", pkts, pend);
         checkOutput("in_ready", inMiso.TREADY, expQ.size() != DEPTH);
`ifdef AXIS_INPUT_QUEUE_STORE_AND_FORWARD_EN
         expValid = (expQ.size() != 0) && (pend != 0 || inPkt || expQ.size() == DEPTH);
`else
         expValid = (expQ.size() != 0);
`endif
         checkOutput("out_valid", outMosi.TVALID, expValid);
         if (outMosi.TVALID && outMiso.TREADY) begin
            if (expQ.size() == 0) begin
               checkOutput("pop_underflow", outMosi.TVALID, 0);
            end else begin
               e = expQ.pop_front();
               checkOutput("pop_data", outMosi.data, e.data);
               if (e.last) begin
                  departed++;
                  inPkt = 1'b0;
               end else if (e.first) begin
                  inPkt = 1'b1;
               end
            end
         end
      end
   end

   // Random downstream backpressure while enabled
   initial begin
      forever begin
         @(posedge clk_i);
         #1;
         if (randReady) outMiso.TREADY = ($urandom_range(0, 99) < readyPct);
      end
   end

   // Watchdog so the bench never hangs
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, checks %0d", checkCount);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      inMosi = '0;
      outMiso.TREADY = 1'b0;
      rst_n_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      checkOutput("reset_count", count, 0);
      checkOutput("reset_valid", outMosi.TVALID, 0);
      checkOutput("reset_ready", inMiso.TREADY, 1);
      checkOutput("reset_pkts", pkts, 0);
      @(negedge clk_i);
      #2 rst_n_i = 1'b1;
      @(posedge clk_i);
      #1;

      // Header with two body beats while the arbiter is stalled
      $display("[TB] header N=2 with stalled output");
      applyStimulus(makeHeader(2), 1'b1, 1'b0);
      checkOutput("t1_count1", count, 1);
`ifdef AXIS_INPUT_QUEUE_STORE_AND_FORWARD_EN
      checkOutput("t1_valid1", outMosi.TVALID, 0);
`else
      checkOutput("t1_valid1", outMosi.TVALID, 1);
`endif
      applyStimulus(axis_data_t'({32'hB0D1_0001, 2'b00}), 1'b0, 1'b0);
      checkOutput("t1_count2", count, 2);
      applyStimulus(axis_data_t'({32'hB0D1_0002, 2'b10}), 1'b0, 1'b1);
      checkOutput("t1_count3", count, 3);
      checkOutput("t1_pkts", pkts, 1);
      checkOutput("t1_valid3", outMosi.TVALID, 1);
      outMiso.TREADY = 1'b1;
      waitDrain(50);
      checkOutput("t1_pkts_end", pkts, 0);

      // Fill with header-only packets across the pointer wrap
      $display("[TB] fill with eight header-only packets");
      outMiso.TREADY = 1'b0;
      for (int i = 0; i < DEPTH; i++) applyStimulus(makeHeader(0), 1'b1, 1'b1);
      checkOutput("t3_full_count", count, DEPTH);
      checkOutput("t3_full_ready", inMiso.TREADY, 0);
      checkOutput("t3_full_pkts", pkts, DEPTH);
      outMiso.TREADY = 1'b1;
      @(posedge clk_i);
      #1 outMiso.TREADY = 1'b0;
      checkOutput("t3_count7", count, DEPTH - 1);
      checkOutput("t3_ready_back", inMiso.TREADY, 1);
      outMiso.TREADY = 1'b1;
      waitDrain(50);

      // Streaming one beat per cycle keeps a single beat in flight
      $display("[TB] continuous push and pop");
      outMiso.TREADY = 1'b1;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(makeHeader(0), 1'b1, 1'b1);
         checkOutput("t4_steady_count", count, 1);
      end
      waitDrain(20);

      // Packet longer than the queue must still drain
      $display("[TB] header N=12 longer than depth");
      sendPacket(12, 0);
      waitDrain(200);
      checkOutput("t5_pkts_end", pkts, 0);

      // Asynchronous reset in the middle of a packet
      $display("[TB] asynchronous reset mid-packet");
      outMiso.TREADY = 1'b0;
      applyStimulus(makeHeader(12), 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(axis_data_t'({$urandom, 2'b00}), 1'b0, 1'b0);
      checkOutput("t6_count5", count, 5);
      @(negedge clk_i);
      #2 rst_n_i = 1'b0;
      #1;
      checkOutput("t6_rst_count", count, 0);
      checkOutput("t6_rst_valid", outMosi.TVALID, 0);
      checkOutput("t6_rst_ready", inMiso.TREADY, 1);
      checkOutput("t6_rst_pkts", pkts, 0);
      expQ.delete();
      completedIn = 0;
      departed = 0;
      inPkt = 1'b0;
      @(negedge clk_i);
      #2 rst_n_i = 1'b1;
      @(posedge clk_i);
      #1 outMiso.TREADY = 1'b1;
      sendPacket(0, 0);
      waitDrain(20);
      checkOutput("t6_pkts_end", pkts, 0);

      // Randomized traffic with random gaps and backpressure
      $display("[TB] random traffic");
      randReady = 1'b1;
      for (int p = 0; p < 150; p++) begin
         if ($urandom_range(0, 99) < 10) sendStray();
         else sendPacket($urandom_range(0, 10), 20);
         if ($urandom_range(0, 99) < 25) idleCycles($urandom_range(1, 4));
      end
      randReady = 1'b0;
      outMiso.TREADY = 1'b1;
      waitDrain(500);
      checkOutput("t7_pkts_end", pkts, 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/axis_input_queue.md
Name: axis_input_queue

Overview:
- Per-channel AXI-Stream flit buffer. It sits directly upstream of each input of the router's round-robin packet arbiter and feeds one of the arbiter's in_mosi_i/in_miso_o lanes.
- It decouples link backpressure from arbitration.
- It tracks packet boundaries using the routing-header beat (TID == ROUTING_HEADER), which carries the count of body beats.
- It optionally holds a packet until it is complete (store-and-forward), so the arbiter's grant is never stalled mid-packet waiting on an upstream link.

Parameters:
- DEPTH, 8, number of flit entries; must be a power of two, >= 2.
- DEPTH_WIDTH, $clog2(DEPTH), pointer width.
- MAX_ROUTERS_X, 4, mesh X size; used only to locate header fields.
- MAX_ROUTERS_X_WIDTH, $clog2(MAX_ROUTERS_X), X field width.
- MAX_ROUTERS_Y, 4, mesh Y size.
- MAX_ROUTERS_Y_WIDTH, $clog2(MAX_ROUTERS_Y), Y field width.

Ports:
- clk_i  input  1  clock; every transfer is sampled on the rising edge.
- rst_n_i  input  1  reset, asynchronous, active-low.
- in_mosi_i  input  axis_mosi_t  upstream link data/valid.
- in_miso_o  output  axis_miso_t  upstream ready.
- out_mosi_o  output  axis_mosi_t  to the arbiter lane.
- out_miso_i  input  axis_miso_t  arbiter lane ready.
- count_o  output  DEPTH_WIDTH+1  number of occupied entries.
- pkts_ready_o  output  DEPTH_WIDTH+1  number of complete packets fully stored.

Behaviour:
- Reset (asynchronous, rst_n_i low):
  - Pointers and count_o go to 0; out_mosi_o.TVALID=0; in_miso_o.TREADY=1; pkts_ready_o=0; RX FSM goes to IDLE.
  - Memory contents are don't-care. A reset mid-packet discards everything; there is no partial recovery.
- Push:
  - in_miso_o.TREADY = !full; full = (count_o == DEPTH).
  - A beat is written when in_mosi_i.TVALID && TREADY. The whole axis_data_t payload is stored, TID included.
- Pop:
  - out_mosi_o.data = head entry, read combinationally from registered storage.
  - Pop occurs when out_mosi_o.TVALID && out_miso_i.TREADY.
- Latency: a beat pushed at edge t is visible at out_mosi_o from t+1. There is no combinational in-to-out bypass.
- Simultaneous push and pop: count_o is unchanged.
  - When full, no push can occur because TREADY is low that cycle.
  - When empty, no pop can occur.
- Pointers wrap modulo DEPTH. count_o is updated as +1 on push-only and -1 on pop-only.
- Header decode:
  - A beat is a header when TID == ROUTING_HEADER.
  - Body length N = TDATA[(XW+YW)*2+7 : (XW+YW)*2], 8 bits unsigned.
  - A packet is the header followed by N body beats. N=0 means a header-only packet.
- RX FSM (on the push side):
  - IDLE: a pushed header with N=0 completes the packet and the FSM stays in IDLE. A pushed header with N>0 loads rx_left=N and moves to BODY.
  - IDLE, non-header beat: pushed as a stray beat, counted as a 1-beat packet, stays in IDLE.
  - BODY: each push decrements rx_left. The push that takes rx_left from 1 to 0 completes the packet and returns to IDLE.
  - BODY, header beat: treated as body; there is no resync.
- TX tracking (on the pop side) uses the same decode on popped beats.
  - A packet leaves the queue when its last beat is popped.
  - pkts_ready_o = completed-in minus departed, using the same +1/-1/simultaneous rule as count_o.

Optional Feature:
- Macro: AXIS_INPUT_QUEUE_STORE_AND_FORWARD_EN.
- Defined:
  - out_mosi_o.TVALID = !empty && (pkts_ready_o != 0 || tx_in_packet || full).
  - tx_in_packet is set once the head packet's header has been popped, and cleared after its last beat is popped.
  - The full term is a cut-through fallback: a packet longer than DEPTH still drains, with no deadlock.
- Undefined:
  - out_mosi_o.TVALID = !empty (pure cut-through).
  - pkts_ready_o is still produced.

Test Plan:
- Reset, then push header(N=2) + 2 body beats with out_miso_i.TREADY=0.
  - count_o: 1,2,3 on successive cycles; pkts_ready_o=1 after the 3rd push; TVALID visible the cycle after the first push (no SF macro).
- Same sequence with SF macro defined, with TREADY=1 held.
  - TVALID stays 0 until the cycle after the 3rd push; then 3 consecutive pops; count_o returns to 0; pkts_ready_o to 0.
- Fill with 8 single-beat header packets (N=0), DEPTH=8.
  - TREADY=0 once count_o=8. One pop drops count_o to 7 and TREADY returns to 1 next cycle.
  - Contents pop out in FIFO order across the pointer wrap.
- Continuous push and pop at 1 beat/cycle for 20 beats.
  - count_o stays constant at 1; data order is preserved.
- SF macro defined, header with N=12 (packet longer than DEPTH=8).
  - Queue fills, the full fallback asserts TVALID, all 13 beats drain with no deadlock.
- Assert rst_n_i asynchronously mid-packet with count_o=5.
  - Immediately: count_o=0, TVALID=0, TREADY=1.
  - A subsequent fresh header(N=0) is queued and popped correctly.
